mux_nx1_seq: RTL

Parametrised, registered N:1 channel selector: the next generation of the 4:1 combinational mux. Adds configurable width and channel count, a registered output with a valid/ready handshake, per-channel valid qualifiers, and an auto-scan mode that round-robins channels with a programmable dwell. Sits between a bank of sample sources and a single downstream consumer, such as a display or serial formatter.

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_nx1_seq_scan_ptr.sv | 59 +++++
 rtl/mux_nx1_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 channel selector.
//   MODE_MANUAL / MODE_SCAN : values of the mode input
//   clog2()                 : pointer width helper, never returns less than 1
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Minimum width of 1 keeps single-value counters legal as vectors.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nx1_seq_scan_ptr.sv
// Auto-scan pointer: dwells DWELL accepted loads on each channel, then steps
// the pointer modulo CHANNELS.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : an accepted load happened while in scan mode
//   restart    : pointer and dwell count back to 0 (wins over en)
//   ptr        : current scan channel
module scan_ptr
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       restart,
  output logic [clog2(CHANNELS)-1:0] ptr
);

  localparam int unsigned PTR_W = clog2(CHANNELS);
  localparam int unsigned DW_W  = clog2(DWELL);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  // Next pointer / dwell count
  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    if (restart) begin
      ptr_d   = '0;
      dwell_d = '0;
    end else if (en) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mux_nx1_seq.sv
// Registered N:1 channel selector with valid/ready output and auto-scan.
//   clk, rst_n   : clock, synchronous active-low reset
//   mode         : 0 manual (sel), 1 auto-scan (internal pointer)
//   sel          : manual channel select
//   scan_restart : reset scan pointer and dwell count
//   in_bus       : channel k at [k*WIDTH +: WIDTH]
//   in_valid     : per-channel valid
//   y, y_valid   : registered sample and its valid flag
//   y_ready      : consumer accepts y
//   y_sel        : channel that produced y
module mux_nx1_seq
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = clog2(CHANNELS),
  parameter int unsigned DWELL    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      scan_restart,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_W-1:0]          y_sel
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SEL_W-1:0] y_sel_q, y_sel_d;

  logic             load_c;
  logic [SEL_W-1:0] ptr_c;
  logic [SEL_W-1:0] eff_sel_c;
  logic [WIDTH-1:0] mux_data_c;
  logic             mux_valid_c;

  // Output register is empty or being drained; y_ready only gates the enable.
  assign load_c    = !y_valid_q || y_ready;
  assign eff_sel_c = (mode == MODE_SCAN) ? ptr_c : sel;

  scan_ptr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_scan_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      ((mode == MODE_SCAN) && load_c),
    .restart (scan_restart),
    .ptr     (ptr_c)
  );

  // Read mux; selects beyond CHANNELS fall through to zero / invalid.
  always_comb begin
    mux_data_c  = '0;
    mux_valid_c = 1'b0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (eff_sel_c == SEL_W'(k)) begin
        mux_data_c  = in_bus[k*WIDTH +: WIDTH];
        mux_valid_c = in_valid[k];
      end
    end
  end

  // Load or hold the output stage
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_sel_d   = y_sel_q;
    if (load_c) begin
      y_d       = mux_data_c;
      y_valid_d = mux_valid_c;
      y_sel_d   = eff_sel_c;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_sel_q   <= y_sel_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_sel   = y_sel_q;

endmodule
